// File: rtl/data_mem_port.sv
// Word/byte load-store responder: 16-bit big-endian word over two byte beats, byte access in one beat.
// Holds stall until the access completes; each beat waits on bus_ack and aborts after TIMEOUT cycles.
module data_mem_port #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              store_byte,
  input  logic              zero_extend,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  localparam logic [7:0]        TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              word_q, word_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;
  logic              timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'h00;
      word_q      <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      hi_q        <= 8'h00;
      lo_q        <= 8'h00;
      rdata_q     <= 16'h0000;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      write_q     <= write_d;
      err_q       <= err_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Ack takes priority over the timeout on the same edge.
  assign timeout_hit = (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    write_d     = write_q;
    err_d       = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      IDLE: begin
        if (mem_read && mem_write) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mem_read || mem_write) begin
          state_d     = BEAT0;
          word_d      = mem_read ? !zero_extend : !store_byte;
          write_d     = mem_write;
          lo_d        = wdata[7:0];
          cnt_d       = 8'h00;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = addr;
          bus_wdata_d = (mem_write && store_byte) ? wdata[7:0] : wdata[15:8];
        end
      end
      BEAT0: begin
        if (bus_ack) begin
          cnt_d = 8'h00;
          if (word_q) begin
            hi_d        = bus_rdata;
            state_d     = BEAT1;
            bus_addr_d  = bus_addr_q + ONE;
            bus_wdata_d = lo_q;
          end else begin
            if (!write_q) rdata_d = {8'h00, bus_rdata};
            state_d   = RESP;
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
          end
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          state_d   = RESP;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      BEAT1: begin
        if (bus_ack) begin
          if (!write_q) rdata_d = {hi_q, bus_rdata};
          state_d   = RESP;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          state_d   = RESP;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall     = ((state_q == IDLE) && (mem_read || mem_write)) ||
                     (state_q == BEAT0) || (state_q == BEAT1);
  assign done      = (state_q == RESP);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboarded bench for data_mem_port: byte-memory bus responder with programmable ack delay.
module tb_data_mem_port;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write, store_byte, zero_extend;
  logic [15:0] addr, wdata, rdata;
  logic        stall, done, err;
  logic        bus_req, bus_we, bus_ack;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  data_mem_port #(.ADDR_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .store_byte(store_byte), .zero_extend(zero_extend),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .done(done), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic [7:0]  stall;
  } res_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } beat_t;

  res_t  res_q[$];
  string tag_q[$];
  beat_t beat_q[$];
  int    n_total = 0;
  int    n_bad   = 0;
  int    ack_dly = 0;
  logic [7:0] mem [0:65535];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus responder: acks after ack_dly wait cycles (-1 = never), checks beats and signal stability.
  initial begin : responder
    logic        in_beat;
    int          w;
    beat_t       snap, eb;
    in_beat = 1'b0;
    w = 0;
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
    mem[16'h0010] = 8'hAB; mem[16'h0011] = 8'hCD; mem[16'h0021] = 8'hF3;
    mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h00;
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        bus_ack = 1'b0;
        in_beat = 1'b0;
      end
      if (!rst_n || !bus_req) begin
        in_beat = 1'b0;
      end else begin
        if (!in_beat) begin
          in_beat = 1'b1;
          w = 0;
          snap = '{addr: bus_addr, we: bus_we, wdata: bus_wdata};
        end else begin
          w++;
          chk("beat_stable", {bus_we, bus_wdata, bus_addr}, {snap.we, snap.wdata, snap.addr});
        end
        if (w == ack_dly) begin
          bus_ack = 1'b1;
          bus_rdata = mem[bus_addr];
          if (beat_q.size() == 0) begin
            chk("unexpected_beat", bus_req, 0);
          end else begin
            eb = beat_q.pop_front();
            chk("beat_addr", bus_addr, eb.addr);
            chk("beat_we", bus_we, eb.we);
            if (eb.we) chk("beat_wdata", bus_wdata, eb.wdata);
          end
          if (bus_we) mem[bus_addr] = bus_wdata;
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on each done pulse.
  initial begin : monitor
    int   stall_cnt;
    logic prev_done;
    res_t r;
    string t;
    stall_cnt = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("done_one_cycle", done, 0);
        if (stall) stall_cnt++;
        if (done) begin
          if (res_q.size() == 0) begin
            chk("unexpected_done", done, 0);
          end else begin
            r = res_q.pop_front();
            t = tag_q.pop_front();
            chk({t, "_rdata"}, rdata, r.rdata);
            chk({t, "_err"}, err, r.err);
            chk({t, "_stall_cycles"}, stall_cnt, r.stall);
            chk({t, "_stall_at_done"}, stall, 0);
            chk({t, "_req_at_done"}, bus_req, 0);
          end
          stall_cnt = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic push_beat(input logic [15:0] a, input logic we, input logic [7:0] wd);
    beat_q.push_back('{addr: a, we: we, wdata: wd});
  endtask

  task automatic access(input string tag, input logic rd, input logic wr, input logic sb,
                        input logic ze, input logic [15:0] a, input logic [15:0] wd,
                        input int dly, input logic [15:0] er, input logic ee, input int est);
    logic got;
    ack_dly = dly;
    res_q.push_back('{rdata: er, err: ee, stall: 8'(est)});
    tag_q.push_back(tag);
    mem_read = rd; mem_write = wr; store_byte = sb; zero_extend = ze;
    addr = a; wdata = wd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; store_byte = 1'b0; zero_extend = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({tag, "_wait_done"}, got, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic got;
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; store_byte = 1'b0; zero_extend = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    #12;
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    push_beat(16'h0010, 1'b0, 8'h00); push_beat(16'h0011, 1'b0, 8'h00);
    access("word_load", 1, 0, 0, 0, 16'h0010, 16'h0000, 0, 16'hABCD, 0, 3);

    push_beat(16'h0021, 1'b0, 8'h00);
    access("lbu", 1, 0, 0, 1, 16'h0021, 16'h0000, 0, 16'h00F3, 0, 2);

    push_beat(16'h0040, 1'b1, 8'h12); push_beat(16'h0041, 1'b1, 8'h34);
    access("word_store", 0, 1, 0, 1, 16'h0040, 16'h1234, 0, 16'h00F3, 0, 3);

    push_beat(16'h0040, 1'b1, 8'h34);
    access("byte_store", 0, 1, 1, 0, 16'h0040, 16'h1234, 0, 16'h00F3, 0, 2);

    push_beat(16'h0040, 1'b0, 8'h00); push_beat(16'h0041, 1'b0, 8'h00);
    access("readback", 1, 0, 1, 0, 16'h0040, 16'h0000, 0, 16'h3434, 0, 3);

    push_beat(16'hFFFF, 1'b0, 8'h00); push_beat(16'h0000, 1'b0, 8'h00);
    access("wrap_wait", 1, 0, 0, 0, 16'hFFFF, 16'h0000, 3, 16'h5AC3, 0, 9);

    access("timeout", 1, 0, 0, 0, 16'h0100, 16'h0000, -1, 16'h5AC3, 1, 16);

    push_beat(16'h0100, 1'b0, 8'h00); push_beat(16'h0101, 1'b0, 8'h00);
    access("ack_at_limit", 1, 0, 0, 0, 16'h0100, 16'h0000, 14, 16'h1122, 0, 31);

    access("illegal", 1, 1, 0, 0, 16'h0010, 16'h0000, 0, 16'h1122, 1, 1);

    // Reset during the second beat of a word load.
    ack_dly = 3;
    push_beat(16'h0010, 1'b0, 8'h00);
    mem_read = 1'b1; addr = 16'h0010;
    @(posedge clk); #1;
    mem_read = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus_req && bus_addr == 16'h0011) got = 1'b1;
    end
    chk("rst_reach_beat1", got, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_bus_req", bus_req, 0);
    chk("rst_async_stall", stall, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_idle_stall", stall, 0);
    chk("rst_idle_bus_req", bus_req, 0);
    chk("rst_cleared_rdata", rdata, 0);
    @(posedge clk); #1;

    push_beat(16'h0021, 1'b0, 8'h00);
    access("lbu_after_rst", 1, 0, 0, 1, 16'h0021, 16'h0000, 0, 16'h00F3, 0, 2);

    repeat (3) @(posedge clk);
    chk("pending_results", res_q.size(), 0);
    chk("pending_beats", beat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
